// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the execute stage.
// Runs MULT/MULTU/DIV/DIVU over DATA_W iterations into the architectural
// HI/LO registers. It stalls the decode/execute latch while busy.
//
// Ports:
//   CLK, nRST      clock (rising edge), asynchronous active-low reset
//   start, op      mul/div instruction in execute; 00 MULT 01 MULTU 10 DIV 11 DIVU
//   rdat1, rdat2   rs (multiplicand/dividend), rt (multiplier/divisor)
//   flush          squash the requested or in-flight operation
//   hi_wen/lo_wen  MTHI/MTLO write of wdat (honoured in IDLE and DONE only)
//   hi, lo         HI/LO registers, read directly by the execute mux
//   stall          hold the decode/execute latch and upstream stages
//   done           one-cycle pulse; the result was committed at the prior edge
module ex_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rdat1,
    input  logic [DATA_W-1:0] rdat2,
    input  logic              flush,
    input  logic              hi_wen,
    input  logic              lo_wen,
    input  logic [DATA_W-1:0] wdat,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              stall,
    output logic              done
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, FIN, DONE} state_t;
    state_t state, next_state;

    logic [CW-1:0]       count;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opb;     // multiplicand magnitude or divisor magnitude
    logic                is_div;
    logic                neg_q;   // product / quotient needs negation
    logic                neg_r;   // remainder takes the dividend's (negative) sign
    logic                dz;      // divide by zero

    logic              accept;
    logic              sgn, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    assign accept = (state == IDLE) && start && !flush;
    assign sgn    = ~op[0];
    assign a_neg  = sgn & rdat1[DATA_W-1];
    assign b_neg  = sgn & rdat2[DATA_W-1];
    assign a_mag  = a_neg ? -rdat1 : rdat1;
    assign b_mag  = b_neg ? -rdat2 : rdat2;

    // One shift-add step.
    logic [DATA_W:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);

    // One restoring-divide step; a borrow out of div_diff means "keep the remainder".
    logic [DATA_W:0] div_shift, div_diff;
    assign div_shift = acc[2*DATA_W-1:DATA_W-1];
    assign div_diff  = div_shift - {1'b0, opb};

    logic [2*DATA_W-1:0] acc_next;
    always_comb begin
        acc_next = acc;
        if (is_div) begin
            if (div_diff[DATA_W])
                acc_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            else
                acc_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[DATA_W-1:1]};
        end
    end

    // Sign correction, consumed in FIN. A zero divisor leaves the remainder
    // as |rdat1|, and re-applying the dividend sign restores rdat1 exactly.
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi, res_lo;
    always_comb begin
        prod   = neg_q ? -acc : acc;
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (is_div) begin
            res_lo = dz ? '1 : (neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
            res_hi = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                stall = start && !flush;
                if (accept) next_state = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (flush)                         next_state = IDLE;
                else if (count == CW'(DATA_W - 1)) next_state = FIN;
            end
            FIN: begin
                stall      = 1'b1;
                next_state = flush ? IDLE : DONE;
            end
            DONE: begin
                // stall is low here, so the latch advances past this instruction
                // and it cannot launch a second time.
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count  <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            count  <= '0;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= op[1] && (rdat2 == '0);
            if (op[1]) begin
                acc <= {{DATA_W{1'b0}}, a_mag};
                opb <= b_mag;
            end else begin
                acc <= {{DATA_W{1'b0}}, b_mag};
                opb <= a_mag;
            end
        end else if (state == BUSY) begin
            acc   <= acc_next;
            count <= count + CW'(1);
        end
    end

    // A commit and an MTHI/MTLO never coincide: writes are honoured only in IDLE/DONE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIN) begin
            if (!flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (state == IDLE || state == DONE) begin
            if (hi_wen) hi <= wdat;
            if (lo_wen) lo <= wdat;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed spec cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_ex_muldiv;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         nRST, start, flush, hi_wen, lo_wen, stall, done;
    logic [1:0]   op;
    logic [W-1:0] rdat1, rdat2, wdat, hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ex_muldiv #(.DATA_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op), .rdat1(rdat1), .rdat2(rdat2),
        .flush(flush), .hi_wen(hi_wen), .lo_wen(lo_wen), .wdat(wdat),
        .hi(hi), .lo(lo), .stall(stall), .done(done)
    );

    // Reference: returns {HI, LO} from the architectural definition.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin p = 64'(sa * sb); return p; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launches one op in the next cycle (cycle 0), holds start until done,
    // and reports the done cycle plus how many cycles stall was wrong.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output int lat, output int sbad);
        lat = -1; sbad = 0; rh = '0; rl = '0;
        @(posedge CLK); #1;
        start = 1'b1; op = o; rdat1 = a; rdat2 = b;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (done) begin
                lat = c; rh = hi; rl = lo;
                if (stall) sbad++;
                break;
            end
            if (!stall) sbad++;
        end
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; start = 0; flush = 0; hi_wen = 0; lo_wen = 0;
        op = 0; rdat1 = 0; rdat2 = 0; wdat = 0;
        repeat (2) @(negedge CLK);
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
        nRST = 1'b1;
    endtask

    task automatic test_multu_latency();
        logic [31:0] rh, rl; int lat, sbad;
        do_op(2'd1, 32'hFFFF_FFFF, 32'h2, rh, rl, lat, sbad);
        checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", lat); end
        checks++; if (sbad !== 0) begin errors++; $display("FAIL multu_stall bad_cycles %0d want 0", sbad); end
        checks++; if (rh !== 32'h1) begin errors++; $display("FAIL multu_hi got %h want 00000001", rh); end
        checks++; if (rl !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", rl); end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [7] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
        logic [31:0] t_a  [7] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'h1234, 32'hFFFF_FFFB};
        logic [31:0] t_b  [7] = '{32'd7, 32'h8000_0000, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] t_hi [7] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h1234, 32'hFFFF_FFFB};
        logic [31:0] t_lo [7] = '{32'hFFFF_FFEB, 32'd0, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] rh, rl; int lat, sbad;
        for (int i = 0; i < 7; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], rh, rl, lat, sbad);
            checks++; if (rh !== t_hi[i] || rl !== t_lo[i] || lat !== 34) begin
                errors++;
                $display("FAIL directed[%0d] got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=34",
                         i, rh, rl, lat, t_hi[i], t_lo[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, rh, rl; logic [1:0] o; logic [63:0] exp; int lat, sbad;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(0, 15);
                2: b = -$urandom_range(1, 15);
                default: b = 32'd0;
            endcase
            exp = ref_model(o, a, b);
            do_op(o, a, b, rh, rl, lat, sbad);
            checks++; if ({rh, rl} !== exp || lat !== 34 || sbad !== 0) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got hi=%h lo=%h lat=%0d sbad=%0d want hi=%h lo=%h",
                         i, o, a, b, rh, rl, lat, sbad, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_flush();
        int dn, st;
        @(posedge CLK); #1; hi_wen = 1; wdat = 32'hAAAA;
        @(posedge CLK); #1; hi_wen = 0; lo_wen = 1; wdat = 32'h0;
        @(posedge CLK); #1; lo_wen = 0;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) begin @(posedge CLK); #1; end
            case (c)
                0:  begin start = 1; op = 2'd1; rdat1 = 32'd3; rdat2 = 32'd4; end
                5:  begin lo_wen = 1; wdat = 32'h5555; end
                6:  lo_wen = 0;
                10: begin start = 0; flush = 1; end
                11: flush = 0;
                default: ;
            endcase
        end
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        dn = 0;
        for (int c = 0; c < 40; c++) begin @(negedge CLK); if (done) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL flush_done pulses %0d want 0", dn); end
        checks++; if (hi !== 32'hAAAA) begin errors++; $display("FAIL flush_hi got %h want 0000aaaa", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL flush_lo got %h want 0", lo); end
        // start together with flush in IDLE must not launch
        @(posedge CLK); #1; start = 1; flush = 1; op = 2'd1; rdat1 = 32'd9; rdat2 = 32'd9;
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_flush_stall got %b want 0", stall); end
        @(posedge CLK); #1; start = 0; flush = 0;
        dn = 0; st = 0;
        for (int c = 0; c < 40; c++) begin @(negedge CLK); if (done) dn++; if (stall) st++; end
        checks++; if (dn !== 0 || st !== 0) begin errors++; $display("FAIL idle_flush_launch done=%0d stall_cycles=%0d want 0 0", dn, st); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL idle_flush_lo got %h want 0", lo); end
    endtask

    task automatic test_mt_concurrent();
        int lat;
        @(posedge CLK); #1;
        start = 1; op = 2'd1; rdat1 = 32'd5; rdat2 = 32'd6; hi_wen = 1; wdat = 32'h1234_5678;
        @(posedge CLK); #1; hi_wen = 0;
        @(negedge CLK);
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_with_start got %h want 12345678", hi); end
        lat = -1;
        for (int c = 1; c < 60; c++) begin
            if (done) begin lat = c; break; end
            @(negedge CLK);
        end
        @(posedge CLK); #1; start = 0;
        checks++; if (lat !== 34 || hi !== 32'd0 || lo !== 32'd30) begin
            errors++; $display("FAIL mt_concurrent got lat=%0d hi=%h lo=%h want 34 0 1e", lat, hi, lo);
        end
    endtask

    task automatic test_hold_and_reset();
        logic [31:0] rh, rl; int lat, sbad, dn;
        do_op(2'd3, 32'd1000, 32'd3, rh, rl, lat, sbad);
        checks++; if (rh !== 32'd1 || rl !== 32'd333 || lat !== 34) begin
            errors++; $display("FAIL hold_result got hi=%h lo=%h lat=%0d want 1 14d 34", rh, rl, lat);
        end
        dn = 0;
        for (int c = 0; c < 40; c++) begin @(negedge CLK); if (done) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL hold_extra_done pulses %0d want 0", dn); end
        checks++; if (hi !== 32'd1 || lo !== 32'd333) begin errors++; $display("FAIL hold_stable got hi=%h lo=%h want 1 14d", hi, lo); end
        // reset in cycle 20 of a multiply
        for (int c = 0; c <= 20; c++) begin
            @(posedge CLK); #1;
            if (c == 0) begin start = 1; op = 2'd1; rdat1 = 32'd7; rdat2 = 32'd9; end
        end
        nRST = 0; start = 0;
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
            errors++; $display("FAIL mid_reset got hi=%h lo=%h stall=%b want 0 0 0", hi, lo, stall);
        end
        @(negedge CLK); nRST = 1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin @(negedge CLK); if (done || stall) dn++; end
        checks++; if (dn !== 0 || lo !== 32'd0) begin errors++; $display("FAIL post_reset activity=%0d lo=%h want 0 0", dn, lo); end
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_directed();
        test_random();
        test_flush();
        test_mt_concurrent();
        test_hold_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the decode/execute latch.
- Takes operand words rdat1/rdat2 and a mul/div opcode from the latch outputs and computes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers.
- While an operation is in flight it drives stall to the hazard unit, which holds the decode/execute latch enable low.
- Also services MTHI/MTLO writes; HI/LO are read combinationally by the execute mux for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand/HI/LO width; the iteration count equals DATA_W.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- start  in  1  decoded mul/div instruction present in execute this cycle
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rdat1  in  DATA_W  rs operand (multiplicand / dividend)
- rdat2  in  DATA_W  rt operand (multiplier / divisor)
- flush  in  1  squash in-flight or requested operation
- hi_wen  in  1  MTHI write
- lo_wen  in  1  MTLO write
- wdat  in  DATA_W  MTHI/MTLO data
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register
- stall  out  1  hold decode/execute latch and upstream stages
- done  out  1  one-cycle pulse; result committed to HI/LO

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous and active-low.
- Reset: state=IDLE; hi=0; lo=0; stall=0; done=0; count=0; internal accumulators=0. Reset mid-operation aborts immediately with no commit.
- States:
  - IDLE: if start && !flush, latch operands and op, take absolute values for MULT/DIV, record result signs, count=0, go to BUSY.
  - BUSY: one iteration per cycle; count increments. Leave BUSY for FIN at the edge where count==DATA_W-1.
  - FIN: apply sign correction; at the edge write HI/LO and go to DONE.
  - DONE: done=1 for this cycle; start is ignored; go to IDLE.
- stall is combinational: (state==BUSY || state==FIN) || (state==IDLE && start && !flush). It is 0 in DONE so the pipeline advances past the instruction, and done prevents a re-launch of that same instruction.
- Latency: start in cycle 0 → BUSY in cycles 1..32 → FIN in cycle 33 → HI/LO visible and done=1 in cycle 34. stall is high in cycles 0–33.
- Multiply: shift-add on unsigned magnitudes producing a 2*DATA_W-bit product. For MULT, negate the product if the operand signs differ. HI=product[63:32], LO=product[31:0].
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Signed: quotient negated if the signs differ; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - 0x80000000 / -1 (DIV) gives LO=0x80000000, HI=0 with no trap.
- Divide by zero (rdat2==0): complete the full latency; LO=0xFFFFFFFF, HI=dividend as given (rdat1, unmodified).
- flush in BUSY or FIN: return to IDLE next edge, leave HI/LO unchanged, no done pulse, stall drops the cycle after. flush in IDLE with start: the operation is not accepted.
- hi_wen/lo_wen: HI/LO written at the edge from wdat, only in IDLE or DONE. Ignored in BUSY/FIN, where the hazard unit guarantees they are not issued.
- start and hi_wen together in IDLE: the write takes effect and the operation still launches; the later commit overwrites it.
- Outputs hi/lo change only on commit, MTHI/MTLO, or reset.

Test Plan:
- MULTU 0xFFFFFFFF*0x00000002, start in cycle 0 → stall high in cycles 0–33; cycle 34: done=1, HI=0x00000001, LO=0xFFFFFFFE, stall=0.
- MULT 0xFFFFFFFD(-3)*0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000*0x80000000 → HI=0x40000000, LO=0.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- DIVU 0x1234/0 → cycle 34: LO=0xFFFFFFFF, HI=0x00001234.
- MTHI 0xAAAA then MULTU 3*4 with flush asserted in cycle 10 → state IDLE in cycle 11, stall=0 in cycle 11, no done, HI=0xAAAA, LO=0 unchanged.
- Hold start high through DONE (stalled latch) → exactly one done pulse and one commit; nRST low in cycle 20 → hi=lo=0, stall=0 immediately.
